// File: rtl/dense_layer_seq.sv
// Time-multiplexed fully-connected layer y = act(W^T*x + b) in signed fixed point.
// N_OUT parallel MAC lanes consume one input element per cycle; result is saturated to BITSIZE.
module dense_layer_seq #(
   parameter int unsigned BITSIZE = 16,
   parameter int unsigned FRAC    = 8,
   parameter int unsigned N_IN    = 6,
   parameter int unsigned N_OUT   = 2,
   parameter int unsigned GUARD   = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   input  logic                            relu_en,
   input  logic [BITSIZE*N_IN-1:0]         x,
   input  logic [BITSIZE*N_IN*N_OUT-1:0]   w,
   input  logic [BITSIZE*N_OUT-1:0]        b,
   output logic                            busy,
   output logic                            done,
   output logic [BITSIZE*N_OUT-1:0]        y
);

   localparam int unsigned ACC_W  = BITSIZE + GUARD;
   localparam int unsigned PROD_W = 2 * BITSIZE;
   localparam int unsigned CNT_W  = (N_IN > 1) ? $clog2(N_IN) : 1;

   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(GUARD+1){1'b0}}, {(BITSIZE-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(GUARD+1){1'b1}}, {(BITSIZE-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_FIN  = 2'd2
   } state_e;

   state_e                      state_q, state_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        relu_q, relu_d;
   logic signed [BITSIZE-1:0]   x_q [N_IN];
   logic signed [BITSIZE-1:0]   x_d [N_IN];
   logic signed [BITSIZE-1:0]   w_q [N_IN][N_OUT];
   logic signed [BITSIZE-1:0]   w_d [N_IN][N_OUT];
   logic signed [ACC_W-1:0]     acc_q [N_OUT];
   logic signed [ACC_W-1:0]     acc_d [N_OUT];
   logic [BITSIZE*N_OUT-1:0]    y_q, y_d;
   logic                        done_q, done_d;
   logic                        busy_q, busy_d;

   logic signed [PROD_W-1:0]    prod_c [N_OUT];
   logic signed [ACC_W-1:0]     term_c [N_OUT];

   // Optional ReLU followed by clamping into the BITSIZE two's-complement range.
   function automatic logic [BITSIZE-1:0] sat_fn(input logic signed [ACC_W-1:0] a,
                                                 input logic                    relu);
      logic signed [ACC_W-1:0] r;
      r = (relu && a[ACC_W-1]) ? '0 : a;
      if (r > SAT_MAX)
         sat_fn = BITSIZE'(SAT_MAX);
      else if (r < SAT_MIN)
         sat_fn = BITSIZE'(SAT_MIN);
      else
         sat_fn = BITSIZE'(r);
   endfunction

   // Per-lane scaled product for the current input element; floor shift, wraps into ACC_W.
   always_comb begin
      for (int o = 0; o < N_OUT; o++) begin
         prod_c[o] = PROD_W'(x_q[cnt_q]) * PROD_W'(w_q[cnt_q][o]);
         term_c[o] = ACC_W'(prod_c[o] >>> FRAC);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      relu_d  = relu_q;
      x_d     = x_q;
      w_d     = w_q;
      acc_d   = acc_q;
      y_d     = y_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               relu_d = relu_en;
               for (int i = 0; i < N_IN; i++) begin
                  x_d[i] = x[BITSIZE*i +: BITSIZE];
                  for (int o = 0; o < N_OUT; o++)
                     w_d[i][o] = w[BITSIZE*N_OUT*i + BITSIZE*o +: BITSIZE];
               end
               for (int o = 0; o < N_OUT; o++)
                  acc_d[o] = ACC_W'($signed(b[BITSIZE*o +: BITSIZE]));
               cnt_d   = '0;
               state_d = S_MAC;
            end
         end
         S_MAC: begin
            for (int o = 0; o < N_OUT; o++)
               acc_d[o] = acc_q[o] + term_c[o];
            if (cnt_q == CNT_W'(N_IN - 1))
               state_d = S_FIN;
            else
               cnt_d = cnt_q + CNT_W'(1);
         end
         S_FIN: begin
            for (int o = 0; o < N_OUT; o++)
               y_d[BITSIZE*o +: BITSIZE] = sat_fn(acc_q[o], relu_q);
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         relu_q  <= 1'b0;
         for (int i = 0; i < N_IN; i++) begin
            x_q[i] <= '0;
            for (int o = 0; o < N_OUT; o++)
               w_q[i][o] <= '0;
         end
         for (int o = 0; o < N_OUT; o++)
            acc_q[o] <= '0;
         y_q     <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         relu_q  <= relu_d;
         x_q     <= x_d;
         w_q     <= w_d;
         acc_q   <= acc_d;
         y_q     <= y_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign y    = y_q;
   assign done = done_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_dense_layer_seq.sv
// Directed bench for dense_layer_seq: default geometry plus an N_IN=1, N_OUT=4 instance.
module tb_dense_layer_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, start, relu_en;
   logic [95:0]   x;
   logic [191:0]  w;
   logic [31:0]   b;
   logic          busy, done;
   logic [31:0]   y;

   logic          reset1, start1, relu1;
   logic [15:0]   x1;
   logic [63:0]   w1;
   logic [63:0]   b1;
   logic          busy1, done1;
   logic [63:0]   y1;

   int total = 0;
   int bad   = 0;
   int e, e2;
   logic seen;

   dense_layer_seq dut (
      .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
      .x(x), .w(w), .b(b), .busy(busy), .done(done), .y(y)
   );

   dense_layer_seq #(.N_IN(1), .N_OUT(4)) dut1 (
      .clk(clk), .reset(reset1), .start(start1), .relu_en(relu1),
      .x(x1), .w(w1), .b(b1), .busy(busy1), .done(done1), .y(y1)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [95:0] rep_x(input logic [15:0] v);
      logic [95:0] r;
      for (int i = 0; i < 6; i++) r[16*i +: 16] = v;
      return r;
   endfunction

   function automatic logic [191:0] mk_w(input logic [15:0] w0, input logic [15:0] w1v);
      logic [191:0] r;
      for (int i = 0; i < 6; i++) begin
         r[32*i +: 16]      = w0;
         r[32*i + 16 +: 16] = w1v;
      end
      return r;
   endfunction

   // Steps at least one falling edge, stops at the first one with done high (bounded).
   task automatic wait_done(output int edges);
      edges = 0;
      do begin
         @(negedge clk);
         edges++;
      end while (done !== 1'b1 && edges < 40);
   endtask

   task automatic run_pass(input logic r);
      int n;
      relu_en = r;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      wait_done(n);
      chk("pass_latency", 64'(n), 64'd7);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; relu_en = 1'b0; x = '0; w = '0; b = '0;
      reset1 = 1'b0; start1 = 1'b0; relu1 = 1'b0; x1 = '0; w1 = '0; b1 = '0;

      #2;
      chk("reset_y",     64'(y), 64'h0);
      chk("reset_done",  64'(done), 64'h0);
      chk("reset_busy",  64'(busy), 64'h0);
      chk("reset1_y",    y1, 64'h0);
      @(negedge clk);
      reset = 1'b1; reset1 = 1'b1;
      @(negedge clk);

      // basic pass with explicit busy/latency/hold checks
      x = rep_x(16'h0100); w = mk_w(16'h0080, 16'h0080); b = {16'hFF00, 16'h0100};
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 64'(busy), 64'h1);
      wait_done(e);
      chk("basic_latency", 64'(e), 64'd7);
      chk("basic_y", 64'(y), 64'h0200_0400);
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'h0);
      chk("busy_after_done", 64'(busy), 64'h0);
      chk("basic_y_held", 64'(y), 64'h0200_0400);

      // floor rounding of negative sub-LSB products
      x = rep_x(16'h0001); w = mk_w(16'hFFFF, 16'h0001); b = '0;
      run_pass(1'b0);
      chk("floor_y", 64'(y), 64'h0000_FFFA);

      // output saturation
      x = rep_x(16'h7FFF); w = mk_w(16'h0100, 16'h0100);
      run_pass(1'b0);
      chk("sat_pos_y", 64'(y), 64'h7FFF_7FFF);
      w = mk_w(16'hFF00, 16'hFF00);
      run_pass(1'b0);
      chk("sat_neg_y", 64'(y), 64'h8000_8000);

      // full-scale products wrap inside the 20-bit accumulator
      w = mk_w(16'h7FFF, 16'h7FFF);
      run_pass(1'b0);
      chk("wrap_pos_y", 64'(y), 64'hFA00_FA00);
      w = mk_w(16'h8000, 16'h8000);
      run_pass(1'b0);
      chk("wrap_neg_y", 64'(y), 64'h0300_0300);

      // ReLU on / off
      x = rep_x(16'h0100); w = mk_w(16'hFF00, 16'h0100); b = '0;
      run_pass(1'b1);
      chk("relu_on_y", 64'(y), 64'h0600_0000);
      run_pass(1'b0);
      chk("relu_off_y", 64'(y), 64'h0600_FA00);

      // start held high: back-to-back passes every 8 cycles
      x = rep_x(16'h0100); w = mk_w(16'h0080, 16'h0080); b = {16'hFF00, 16'h0100};
      relu_en = 1'b0;
      start = 1'b1;
      @(negedge clk);
      wait_done(e);
      chk("cont_first", 64'(e), 64'd7);
      wait_done(e2);
      chk("cont_period", 64'(e2), 64'd8);
      chk("cont_y", 64'(y), 64'h0200_0400);
      start = 1'b0;
      @(negedge clk);
      chk("cont_stop_busy", 64'(busy), 64'h0);

      // extra starts and operand changes mid-pass are ignored
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      x = rep_x(16'h7FFF); w = mk_w(16'h1234, 16'h4321); b = 32'hDEAD_BEEF; relu_en = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(e);
      chk("ignore_latency", 64'(e), 64'd3);
      chk("captured_y", 64'(y), 64'h0200_0400);
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      chk("no_extra_done", 64'(seen), 64'h0);

      // abort during MAC at i=3
      x = rep_x(16'h0100); w = mk_w(16'h0080, 16'h0080); b = {16'hFF00, 16'h0100};
      relu_en = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("abort_y", 64'(y), 64'h0);
      chk("abort_busy", 64'(busy), 64'h0);
      chk("abort_done", 64'(done), 64'h0);
      @(negedge clk);
      reset = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      chk("abort_no_done", 64'(seen), 64'h0);
      run_pass(1'b0);
      chk("rerun_y", 64'(y), 64'h0200_0400);

      // N_IN=1, N_OUT=4 instance
      x1 = 16'h0200;
      w1 = {16'h7FFF, 16'hFF00, 16'h0080, 16'h0100};
      b1 = {4{16'h0010}};
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      e = 0;
      do begin
         @(negedge clk);
         e++;
      end while (done1 !== 1'b1 && e < 20);
      chk("n1_latency", 64'(e), 64'd2);
      chk("n1_y", y1, 64'h7FFF_FE10_0110_0210);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
